pc_pipeline_chain: RTL and testbench

Parametrised successor to the hard-wired fetch-PC / stage-register chain in the ARM top level. It generates the fetch PC and carries a {PC, valid} token through a configurable number of pipeline stage registers. Freeze (stall with bubble insertion) and branch redirect with younger-stage flush are live behaviour, not tied-off constants. It also keeps retire and squash counters for debug and performance.

---
 rtl/pc_pipeline_chain.sv | 104 ++++++++++
 tb/tb_pc_pipeline_chain.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_pipeline_chain.sv
// Fetch PC generator plus a parametrised chain of {PC, valid} stage registers.
// Supports freeze with bubble insertion, branch redirect with flush, retire/squash counters.
module pc_pipeline_chain #(
    parameter int ADDR_W = 32,
    parameter int STAGES = 5,
    parameter int PC_STEP = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int STALL_STAGE = 1,
    parameter int BRANCH_STAGE = 2,
    parameter int COUNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       Branch_taken,
    input  logic [ADDR_W-1:0]          BranchAddr,
    output logic [ADDR_W-1:0]          pc_fetch,
    output logic [STAGES*ADDR_W-1:0]   stage_pc,
    output logic [STAGES-1:0]          stage_valid,
    output logic [COUNT_W-1:0]         retire_count,
    output logic [COUNT_W-1:0]         squash_count
);

    if (STALL_STAGE < 1 || STALL_STAGE > BRANCH_STAGE ||
        BRANCH_STAGE > STAGES - 2) begin : g_bad_cfg
        $error("pc_pipeline_chain: illegal STALL_STAGE/BRANCH_STAGE/STAGES");
    end

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              valid;
    } token_t;

    localparam token_t BUBBLE = '0;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    token_t             tok_q [STAGES];
    token_t             tok_d [STAGES];
    logic [COUNT_W-1:0] retire_q, retire_d;
    logic [COUNT_W-1:0] squash_q, squash_d;
    logic [COUNT_W:0]   sq_sum;

    always_comb begin
        pc_d = pc_q + STEP;
        tok_d[0] = '{pc: pc_q + STEP, valid: 1'b1};
        for (int k = 1; k < STAGES; k++) begin
            tok_d[k] = tok_q[k-1];
        end
        sq_sum = {1'b0, squash_q};
        if (Branch_taken) begin
            pc_d = BranchAddr;
            for (int k = 0; k <= BRANCH_STAGE; k++) begin
                tok_d[k] = BUBBLE;
            end
            for (int k = 0; k < BRANCH_STAGE; k++) begin
                sq_sum = sq_sum + (COUNT_W+1)'(tok_q[k].valid);
            end
        end else if (freeze) begin
            pc_d = pc_q;
            for (int k = 0; k < STALL_STAGE; k++) begin
                tok_d[k] = tok_q[k];
            end
            tok_d[STALL_STAGE] = BUBBLE;
        end
    end

    // Both counters stick at all-ones instead of wrapping
    always_comb begin
        squash_d = sq_sum[COUNT_W] ? '1 : sq_sum[COUNT_W-1:0];
        retire_d = retire_q;
        if (tok_q[STAGES-1].valid && !(&retire_q)) begin
            retire_d = retire_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            retire_q <= '0;
            squash_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                tok_q[k] <= BUBBLE;
            end
        end else begin
            pc_q     <= pc_d;
            retire_q <= retire_d;
            squash_q <= squash_d;
            for (int k = 0; k < STAGES; k++) begin
                tok_q[k] <= tok_d[k];
            end
        end
    end

    assign pc_fetch     = pc_q;
    assign retire_count = retire_q;
    assign squash_count = squash_q;

    for (genvar g = 0; g < STAGES; g++) begin : g_out
        assign stage_pc[g*ADDR_W +: ADDR_W] = tok_q[g].pc;
        assign stage_valid[g]               = tok_q[g].valid;
    end

endmodule

// File: tb/tb_pc_pipeline_chain.sv
// Bench for pc_pipeline_chain: directed scenarios plus random freeze/branch
// traffic against a reference model; a second instance covers PC wrap and saturation.
module tb_pc_pipeline_chain;

    logic         clk = 1'b0;
    logic         rst;
    logic         freeze;
    logic         br;
    logic [31:0]  addr;

    logic [31:0]  pc1, ret1, sq1;
    logic [159:0] spc1;
    logic [4:0]   sv1;
    logic [31:0]  pc2;
    logic [159:0] spc2;
    logic [4:0]   sv2;
    logic [2:0]   ret2, sq2;

    int checks = 0;
    int errors = 0;

    pc_pipeline_chain dut1 (
        .clk(clk), .rst(rst), .freeze(freeze), .Branch_taken(br),
        .BranchAddr(addr), .pc_fetch(pc1), .stage_pc(spc1),
        .stage_valid(sv1), .retire_count(ret1), .squash_count(sq1)
    );

    pc_pipeline_chain #(.RESET_PC(32'hFFFF_FFF8), .COUNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .freeze(freeze), .Branch_taken(br),
        .BranchAddr(addr), .pc_fetch(pc2), .stage_pc(spc2),
        .stage_valid(sv2), .retire_count(ret2), .squash_count(sq2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      fetch;
        logic [4:0][31:0] pc;
        logic [4:0]       v;
        logic [31:0]      ret;
        logic [31:0]      sq;
    } mdl_t;

    mdl_t m1, m2;

    function automatic longint sat(longint x, longint mx);
        return (x > mx) ? mx : x;
    endfunction

    function automatic mdl_t mreset(logic [31:0] rpc);
        mdl_t r;
        r = '0;
        r.fetch = rpc;
        return r;
    endfunction

    // Default geometry: stall stage 1, branch stage 2, five stages
    function automatic mdl_t mstep(mdl_t s, bit f, bit b,
                                   logic [31:0] a, longint cmax);
        mdl_t n;
        n = s;
        if (s.v[4]) n.ret = 32'(sat(longint'(s.ret) + 1, cmax));
        if (b) begin
            n.fetch = a;
            n.sq = 32'(sat(longint'(s.sq) + s.v[0] + s.v[1], cmax));
            n.pc[4] = s.pc[3]; n.v[4] = s.v[3];
            n.pc[3] = s.pc[2]; n.v[3] = s.v[2];
            for (int k = 0; k < 3; k++) begin
                n.pc[k] = '0; n.v[k] = 1'b0;
            end
        end else if (f) begin
            n.pc[4:2] = s.pc[3:1]; n.v[4:2] = s.v[3:1];
            n.pc[1] = '0; n.v[1] = 1'b0;
        end else begin
            n.fetch = s.fetch + 32'd4;
            n.pc = {s.pc[3:0], s.fetch + 32'd4};
            n.v = {s.v[3:0], 1'b1};
        end
        return n;
    endfunction

    task automatic tick(bit f, bit b, logic [31:0] a);
        freeze = f; br = b; addr = a;
        @(posedge clk);
        m1 = mstep(m1, f, b, a, 64'hFFFF_FFFF);
        m2 = mstep(m2, f, b, a, 7);
        #1;
    endtask

    task automatic do_reset();
        freeze = 0; br = 0; addr = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m1 = mreset(32'h0);
        m2 = mreset(32'hFFFF_FFF8);
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 0; br = 0; addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pc1 !== 32'h0 || spc1 !== '0 || sv1 !== '0) begin
            errors++;
            $display("FAIL reset_state pc=%h v=%b spc=%h want 0", pc1, sv1, spc1);
        end
        checks++;
        if (ret1 !== 32'h0 || sq1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_counters ret=%0d sq=%0d want 0", ret1, sq1);
        end
        checks++;
        if (pc2 !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL reset_pc2 got %h want fffffff8", pc2);
        end
        @(negedge clk);
        rst = 1'b0;
        m1 = mreset(32'h0);
        m2 = mreset(32'hFFFF_FFF8);
    endtask

    task automatic test_free_run();
        logic [4:0] vexp;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            tick(0, 0, '0);
            vexp = (i >= 5) ? 5'h1F : 5'((1 << i) - 1);
            checks++;
            if (pc1 !== 32'(4 * i) || sv1 !== vexp) begin
                errors++;
                $display("FAIL free_run edge=%0d pc=%h want %h v=%b want %b",
                         i, pc1, 32'(4 * i), sv1, vexp);
            end
        end
        checks++;
        if (spc1[31:0] !== 32'd40 || ret1 !== 32'd5) begin
            errors++;
            $display("FAIL free_run_end s0=%h want 28 ret=%0d want 5",
                     spc1[31:0], ret1);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seq [4];
        seq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc2 !== seq[i]) begin
                errors++;
                $display("FAIL wrap step=%0d pc=%h want %h", i, pc2, seq[i]);
            end
            if (i == 1) begin
                checks++;
                if (spc2[31:0] !== 32'hFFFF_FFFC) begin
                    errors++;
                    $display("FAIL wrap_s0 got %h want fffffffc", spc2[31:0]);
                end
            end
            tick(0, 0, '0);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        repeat (8) tick(0, 0, '0);
        for (int i = 0; i < 2; i++) begin
            tick(1, 0, '0);
            checks++;
            if (pc1 !== 32'h20 || spc1[31:0] !== 32'h20 || !sv1[0] ||
                sv1[1] !== 1'b0 || spc1[63:32] !== 32'h0) begin
                errors++;
                $display("FAIL freeze edge=%0d pc=%h s0=%h v=%b s1=%h",
                         i, pc1, spc1[31:0], sv1, spc1[63:32]);
            end
            if (i == 0) begin
                checks++;
                if (spc1[95:64] !== 32'h1C || spc1[159:128] !== 32'h14) begin
                    errors++;
                    $display("FAIL freeze_shift s2=%h want 1c s4=%h want 14",
                             spc1[95:64], spc1[159:128]);
                end
            end
        end
        tick(0, 0, '0);
        checks++;
        if (pc1 !== 32'h24 || spc1[31:0] !== 32'h24 || spc1[63:32] !== 32'h20) begin
            errors++;
            $display("FAIL freeze_resume1 pc=%h s0=%h s1=%h", pc1, spc1[31:0], spc1[63:32]);
        end
        tick(0, 0, '0);
        checks++;
        if (pc1 !== 32'h28) begin
            errors++;
            $display("FAIL freeze_resume2 pc=%h want 28", pc1);
        end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (6) tick(0, 0, '0);
        tick(0, 1, 32'h100);
        checks++;
        if (pc1 !== 32'h100 || sv1[2:0] !== 3'b000 || !sv1[3] ||
            spc1[127:96] !== 32'h10 || sq1 !== 32'd2) begin
            errors++;
            $display("FAIL branch pc=%h v=%b s3=%h sq=%0d want 100/x1000/10/2",
                     pc1, sv1, spc1[127:96], sq1);
        end
        tick(0, 0, '0);
        checks++;
        if (spc1[31:0] !== 32'h104 || !sv1[0]) begin
            errors++;
            $display("FAIL branch_next s0=%h v=%b want 104", spc1[31:0], sv1);
        end
    endtask

    task automatic test_branch_freeze();
        tick(1, 1, 32'h200);
        checks++;
        if (pc1 !== 32'h200 || sv1[2:0] !== 3'b000 || sq1 !== 32'd3) begin
            errors++;
            $display("FAIL branch_freeze pc=%h v=%b sq=%0d want 200/xx000/3",
                     pc1, sv1, sq1);
        end
    endtask

    task automatic test_random();
        bit f, b;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            f = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 15);
            tick(f, b, $urandom);
            checks++;
            if (pc1 !== m1.fetch || spc1 !== m1.pc || sv1 !== m1.v ||
                ret1 !== m1.ret || sq1 !== m1.sq) begin
                errors++;
                $display("FAIL rand1 cyc=%0d pc=%h/%h v=%b/%b ret=%0d/%0d sq=%0d/%0d spc=%h want %h",
                         c, pc1, m1.fetch, sv1, m1.v, ret1, m1.ret, sq1, m1.sq, spc1, m1.pc);
            end
            checks++;
            if (pc2 !== m2.fetch || spc2 !== m2.pc || sv2 !== m2.v ||
                ret2 !== m2.ret[2:0] || sq2 !== m2.sq[2:0]) begin
                errors++;
                $display("FAIL rand2 cyc=%0d pc=%h/%h v=%b/%b ret=%0d/%0d sq=%0d/%0d",
                         c, pc2, m2.fetch, sv2, m2.v, ret2, m2.ret, sq2, m2.sq);
            end
        end
    endtask

    task automatic test_saturation();
        repeat (12) tick(0, 0, '0);
        checks++;
        if (ret2 !== 3'd7 || sq2 !== 3'd7) begin
            errors++;
            $display("FAIL saturation ret=%0d sq=%0d want 7/7", ret2, sq2);
        end
    endtask

    task automatic test_async_reset();
        repeat (6) tick(0, 0, '0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (pc1 !== 32'h0 || spc1 !== '0 || sv1 !== '0 || ret1 !== '0 ||
            sq1 !== '0 || pc2 !== 32'hFFFF_FFF8 || ret2 !== '0) begin
            errors++;
            $display("FAIL async_reset pc=%h v=%b ret=%0d sq=%0d pc2=%h",
                     pc1, sv1, ret1, sq1, pc2);
        end
        #1 rst = 1'b0;
        m1 = mreset(32'h0);
        m2 = mreset(32'hFFFF_FFF8);
        tick(0, 0, '0);
        checks++;
        if (spc1[31:0] !== 32'h4 || sv1 !== 5'b00001 || pc1 !== 32'h4 ||
            spc2[31:0] !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL async_reset_post s0=%h v=%b pc=%h s0b=%h",
                     spc1[31:0], sv1, pc1, spc2[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_wrap();
        test_freeze();
        test_branch();
        test_branch_freeze();
        test_random();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
